// File: rtl/rob_commit.sv
// Retirement end of the reorder buffer: allocates at the tail, takes CDB completions,
// and retires one ready entry per clock from the head, flushing on a mispredicted branch.
module rob_commit #(
  parameter int unsigned ROB_DEPTH = 8,
  parameter int unsigned IDX_W     = 3,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned RD_W      = 4,
  parameter int unsigned FUNC_W    = 4
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic [FUNC_W-1:0] alloc_func,
  input  logic [RD_W-1:0]   alloc_rd,
  output logic              alloc_ready,
  output logic [IDX_W-1:0]  alloc_idx,
  input  logic              cdb_valid,
  input  logic [IDX_W-1:0]  cdb_idx,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              commit_valid,
  output logic [IDX_W-1:0]  commit_idx,
  output logic [RD_W-1:0]   commit_rd,
  output logic [DATA_W-1:0] commit_data,
  output logic [FUNC_W-1:0] commit_func,
  output logic              add_release,
  output logic              mul_release,
  output logic              flush,
  output logic [IDX_W:0]    rob_count
);

  localparam logic [FUNC_W-1:0] FuncBranch = FUNC_W'(4);
  localparam logic [IDX_W:0]    DepthW     = (IDX_W+1)'(ROB_DEPTH);

  // Per-entry state
  logic [ROB_DEPTH-1:0] valid_q, valid_d;
  logic [ROB_DEPTH-1:0] ready_q, ready_d;
  logic [FUNC_W-1:0]    func_q [ROB_DEPTH];
  logic [FUNC_W-1:0]    func_d [ROB_DEPTH];
  logic [RD_W-1:0]      rd_q   [ROB_DEPTH];
  logic [RD_W-1:0]      rd_d   [ROB_DEPTH];
  logic [DATA_W-1:0]    data_q [ROB_DEPTH];
  logic [DATA_W-1:0]    data_d [ROB_DEPTH];

  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;

  // Registered commit outputs
  logic              cvalid_q, cvalid_d;
  logic [IDX_W-1:0]  cidx_q, cidx_d;
  logic [RD_W-1:0]   crd_q, crd_d;
  logic [DATA_W-1:0] cdata_q, cdata_d;
  logic [FUNC_W-1:0] cfunc_q, cfunc_d;
  logic              add_q, add_d;
  logic              mul_q, mul_d;
  logic              flush_q, flush_d;

  logic alloc_fire;
  logic commit_fire;
  logic mispredict;

  always_comb begin
    alloc_ready = !rst && (count_q < DepthW);
    alloc_fire  = alloc_valid && alloc_ready;
    commit_fire = (count_q != '0) && valid_q[head_q] && ready_q[head_q];
    mispredict  = commit_fire && (func_q[head_q] == FuncBranch) && data_q[head_q][0];
  end

  // Entry next state: CDB write, commit clear, then flush or allocation.
  always_comb begin
    valid_d = valid_q;
    ready_d = ready_q;
    func_d  = func_q;
    rd_d    = rd_q;
    data_d  = data_q;
    if (cdb_valid && valid_q[cdb_idx] && !(commit_fire && (cdb_idx == head_q))) begin
      ready_d[cdb_idx] = 1'b1;
      data_d[cdb_idx]  = cdb_data;
    end
    if (commit_fire) begin
      valid_d[head_q] = 1'b0;
    end
    if (mispredict) begin
      valid_d = '0;
    end else if (alloc_fire) begin
      valid_d[tail_q] = 1'b1;
      ready_d[tail_q] = 1'b0;
      func_d[tail_q]  = alloc_func;
      rd_d[tail_q]    = alloc_rd;
      data_d[tail_q]  = '0;
    end
  end

  always_comb begin
    head_d = head_q + IDX_W'(commit_fire);
    if (mispredict) begin
      tail_d  = head_q + IDX_W'(1);
      count_d = '0;
    end else begin
      tail_d  = tail_q + IDX_W'(alloc_fire);
      count_d = count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(commit_fire);
    end
  end

  // Commit outputs hold their last payload when nothing retires.
  always_comb begin
    cvalid_d = commit_fire;
    cidx_d   = cidx_q;
    crd_d    = crd_q;
    cdata_d  = cdata_q;
    cfunc_d  = cfunc_q;
    add_d    = 1'b0;
    mul_d    = 1'b0;
    flush_d  = mispredict;
    if (commit_fire) begin
      cidx_d  = head_q;
      crd_d   = rd_q[head_q];
      cdata_d = data_q[head_q];
      cfunc_d = func_q[head_q];
      add_d   = (func_q[head_q][FUNC_W-1:1] == '0);
      mul_d   = (func_q[head_q][FUNC_W-1:1] == (FUNC_W-1)'(1));
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      valid_q  <= '0;
      ready_q  <= '0;
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        func_q[i] <= '0;
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      cvalid_q <= 1'b0;
      cidx_q   <= '0;
      crd_q    <= '0;
      cdata_q  <= '0;
      cfunc_q  <= '0;
      add_q    <= 1'b0;
      mul_q    <= 1'b0;
      flush_q  <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      func_q   <= func_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      cvalid_q <= cvalid_d;
      cidx_q   <= cidx_d;
      crd_q    <= crd_d;
      cdata_q  <= cdata_d;
      cfunc_q  <= cfunc_d;
      add_q    <= add_d;
      mul_q    <= mul_d;
      flush_q  <= flush_d;
    end
  end

  always_comb begin
    alloc_idx    = tail_q;
    rob_count    = count_q;
    commit_valid = cvalid_q;
    commit_idx   = cidx_q;
    commit_rd    = crd_q;
    commit_data  = cdata_q;
    commit_func  = cfunc_q;
    add_release  = add_q;
    mul_release  = mul_q;
    flush        = flush_q;
  end

endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_rob_commit;

  localparam int Depth = 8;

  logic        clk1 = 1'b0;
  logic        rst = 1'b1;
  logic        alloc_valid = 1'b0;
  logic [3:0]  alloc_func = '0;
  logic [3:0]  alloc_rd = '0;
  logic        alloc_ready;
  logic [2:0]  alloc_idx;
  logic        cdb_valid = 1'b0;
  logic [2:0]  cdb_idx = '0;
  logic [15:0] cdb_data = '0;
  logic        commit_valid;
  logic [2:0]  commit_idx;
  logic [3:0]  commit_rd;
  logic [15:0] commit_data;
  logic [3:0]  commit_func;
  logic        add_release;
  logic        mul_release;
  logic        flush;
  logic [3:0]  rob_count;

  rob_commit #(
    .ROB_DEPTH(8), .IDX_W(3), .DATA_W(16), .RD_W(4), .FUNC_W(4)
  ) dut (
    .clk1(clk1), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_func(alloc_func), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .cdb_valid(cdb_valid), .cdb_idx(cdb_idx), .cdb_data(cdb_data),
    .commit_valid(commit_valid), .commit_idx(commit_idx), .commit_rd(commit_rd),
    .commit_data(commit_data), .commit_func(commit_func),
    .add_release(add_release), .mul_release(mul_release), .flush(flush),
    .rob_count(rob_count)
  );

  always #5 clk1 = ~clk1;

  int total = 0;
  int bad = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  // Reference model: program-ordered list of live entries.
  typedef struct {
    int          idx;
    logic [3:0]  func;
    logic [3:0]  rd;
    bit          rdy;
    logic [15:0] data;
  } ent_t;

  ent_t        q[$];
  int          m_tail = 0;
  bit          live = 1'b0;
  logic        exp_cv = 1'b0;
  logic [2:0]  exp_cidx = '0;
  logic [3:0]  exp_crd = '0;
  logic [15:0] exp_cdata = '0;
  logic [3:0]  exp_cfunc = '0;
  logic        exp_add = 1'b0;
  logic        exp_mul = 1'b0;
  logic        exp_flush = 1'b0;

  always @(posedge clk1) begin
    ent_t c;
    bit   do_alloc;
    bit   do_commit;
    bit   mis;
    if (rst) begin
      q.delete();
      m_tail = 0;
      live = 1'b1;
      {exp_cv, exp_cidx, exp_crd, exp_cdata, exp_cfunc, exp_add, exp_mul, exp_flush} = '0;
    end else begin
      do_alloc  = alloc_valid && (q.size() < Depth);
      do_commit = (q.size() > 0) && q[0].rdy;
      mis = 1'b0;
      exp_cv = 1'b0;
      exp_add = 1'b0;
      exp_mul = 1'b0;
      exp_flush = 1'b0;
      if (do_commit) begin
        c = q.pop_front();
        exp_cv    = 1'b1;
        exp_cidx  = 3'(c.idx);
        exp_crd   = c.rd;
        exp_cdata = c.data;
        exp_cfunc = c.func;
        exp_add   = (c.func == 4'd0) || (c.func == 4'd1);
        exp_mul   = (c.func == 4'd2) || (c.func == 4'd3);
        mis       = (c.func == 4'd4) && c.data[0];
        exp_flush = mis;
      end
      // The retired entry is already gone, so a same-edge CDB to it is dropped.
      if (cdb_valid) begin
        foreach (q[i]) begin
          if (q[i].idx == int'(cdb_idx)) begin
            q[i].rdy  = 1'b1;
            q[i].data = cdb_data;
          end
        end
      end
      if (mis) begin
        q.delete();
        m_tail = (c.idx + 1) % Depth;
      end else if (do_alloc) begin
        q.push_back(ent_t'{m_tail, alloc_func, alloc_rd, 1'b0, 16'h0});
        m_tail = (m_tail + 1) % Depth;
      end
    end
  end

  always @(negedge clk1) begin
    if (live) begin
      chk("alloc_ready", 32'(alloc_ready), 32'(!rst && (q.size() < Depth)));
      chk("alloc_idx", 32'(alloc_idx), 32'(m_tail));
      chk("rob_count", 32'(rob_count), 32'(q.size()));
      chk("commit_valid", 32'(commit_valid), 32'(exp_cv));
      chk("commit_idx", 32'(commit_idx), 32'(exp_cidx));
      chk("commit_rd", 32'(commit_rd), 32'(exp_crd));
      chk("commit_data", 32'(commit_data), 32'(exp_cdata));
      chk("commit_func", 32'(commit_func), 32'(exp_cfunc));
      chk("add_release", 32'(add_release), 32'(exp_add));
      chk("mul_release", 32'(mul_release), 32'(exp_mul));
      chk("flush", 32'(flush), 32'(exp_flush));
    end
  end

  task automatic drive(input logic r, input logic av, input logic [3:0] af,
                       input logic [3:0] ard, input logic cv, input logic [2:0] ci,
                       input logic [15:0] cd);
    rst = r;
    alloc_valid = av;
    alloc_func = af;
    alloc_rd = ard;
    cdb_valid = cv;
    cdb_idx = ci;
    cdb_data = cd;
    @(posedge clk1);
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 3'h0, 16'h0);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 3'h0, 16'h0);
  endtask

  task automatic alloc(input logic [3:0] f, input logic [3:0] r);
    drive(1'b0, 1'b1, f, r, 1'b0, 3'h0, 16'h0);
  endtask

  task automatic cdb(input logic [2:0] i, input logic [15:0] d);
    drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, i, d);
  endtask

  initial begin
    logic       av;
    logic       cv;
    logic [3:0] f;
    logic [2:0] ci;
    int         cdb_pct;

    // In-order commit of out-of-order completions
    do_reset();
    chk("lit_reset_count", 32'(rob_count), 32'd0);
    chk("lit_reset_ready_low", 32'(alloc_ready), 32'd0);
    alloc(4'h0, 4'd1);
    alloc(4'h0, 4'd2);
    alloc(4'h0, 4'd3);
    chk("lit_s1_count", 32'(rob_count), 32'd3);
    cdb(3'd2, 16'h0011);
    cdb(3'd1, 16'h0022);
    cdb(3'd0, 16'h0033);
    chk("lit_s1_no_early_commit", 32'(commit_valid), 32'd0);
    idle();
    chk("lit_s1_c0_valid", 32'(commit_valid), 32'd1);
    chk("lit_s1_c0_idx", 32'(commit_idx), 32'd0);
    chk("lit_s1_c0_data", 32'(commit_data), 32'h33);
    chk("lit_s1_c0_add", 32'(add_release), 32'd1);
    idle();
    chk("lit_s1_c1_idx", 32'(commit_idx), 32'd1);
    chk("lit_s1_c1_data", 32'(commit_data), 32'h22);
    chk("lit_s1_c1_rd", 32'(commit_rd), 32'd2);
    idle();
    chk("lit_s1_c2_idx", 32'(commit_idx), 32'd2);
    chk("lit_s1_c2_data", 32'(commit_data), 32'h11);
    idle();
    chk("lit_s1_done_valid", 32'(commit_valid), 32'd0);
    chk("lit_s1_done_count", 32'(rob_count), 32'd0);

    // Full ROB, ignored allocation, full blocks alloc on a commit edge, wrap
    do_reset();
    for (int i = 0; i < 8; i++) alloc(4'h1, 4'(i));
    chk("lit_s2_full_ready", 32'(alloc_ready), 32'd0);
    chk("lit_s2_full_count", 32'(rob_count), 32'd8);
    alloc(4'h1, 4'd9);
    chk("lit_s2_ninth_count", 32'(rob_count), 32'd8);
    chk("lit_s2_ninth_tail", 32'(alloc_idx), 32'd0);
    cdb(3'd0, 16'h0055);
    alloc(4'h0, 4'd1);
    chk("lit_s2_commit", 32'(commit_valid), 32'd1);
    chk("lit_s2_after_count", 32'(rob_count), 32'd7);
    chk("lit_s2_after_ready", 32'(alloc_ready), 32'd1);
    chk("lit_s2_wrap_idx", 32'(alloc_idx), 32'd0);

    // Simultaneous alloc and commit
    do_reset();
    for (int i = 0; i < 5; i++) alloc(4'h0, 4'(i));
    cdb(3'd0, 16'h0077);
    alloc(4'h1, 4'd6);
    chk("lit_s3_commit", 32'(commit_valid), 32'd1);
    chk("lit_s3_count", 32'(rob_count), 32'd5);
    chk("lit_s3_tail", 32'(alloc_idx), 32'd6);

    // Mispredicted branch flush
    do_reset();
    alloc(4'h2, 4'd1);
    alloc(4'h4, 4'd2);
    alloc(4'h0, 4'd3);
    cdb(3'd0, 16'h1234);
    cdb(3'd1, 16'h0001);
    chk("lit_s4_mul_commit_idx", 32'(commit_idx), 32'd0);
    chk("lit_s4_mul_release", 32'(mul_release), 32'd1);
    chk("lit_s4_mul_no_add", 32'(add_release), 32'd0);
    drive(1'b0, 1'b1, 4'h0, 4'd5, 1'b1, 3'd2, 16'h0009);
    chk("lit_s4_flush", 32'(flush), 32'd1);
    chk("lit_s4_br_idx", 32'(commit_idx), 32'd1);
    chk("lit_s4_br_no_add", 32'(add_release), 32'd0);
    chk("lit_s4_count", 32'(rob_count), 32'd0);
    chk("lit_s4_tail", 32'(alloc_idx), 32'd2);
    idle();
    chk("lit_s4_no_more_commit", 32'(commit_valid), 32'd0);
    chk("lit_s4_flush_pulse", 32'(flush), 32'd0);

    // CDB to an unallocated entry is ignored
    do_reset();
    cdb(3'd5, 16'hBEEF);
    chk("lit_s5_count", 32'(rob_count), 32'd0);
    chk("lit_s5_tail", 32'(alloc_idx), 32'd0);
    for (int i = 0; i < 6; i++) alloc(4'h0, 4'(i));
    for (int i = 0; i < 5; i++) cdb(3'(i), 16'(i + 1));
    idle();
    idle();
    idle();
    chk("lit_s5_stuck_count", 32'(rob_count), 32'd1);
    chk("lit_s5_last_idx", 32'(commit_idx), 32'd4);
    chk("lit_s5_last_data", 32'(commit_data), 32'd5);
    chk("lit_s5_no_commit", 32'(commit_valid), 32'd0);

    // Reset with ready entries pending
    do_reset();
    for (int i = 0; i < 4; i++) alloc(4'h0, 4'(i));
    for (int i = 3; i >= 0; i--) cdb(3'(i), 16'(16'hA0 + i));
    do_reset();
    chk("lit_s6_no_commit", 32'(commit_valid), 32'd0);
    chk("lit_s6_count", 32'(rob_count), 32'd0);
    chk("lit_s6_tail", 32'(alloc_idx), 32'd0);
    chk("lit_s6_ready_in_reset", 32'(alloc_ready), 32'd0);
    idle();
    chk("lit_s6_ready_after", 32'(alloc_ready), 32'd1);
    chk("lit_s6_still_no_commit", 32'(commit_valid), 32'd0);

    // Random traffic; second half starves the CDB so the ROB fills up
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cdb_pct = (n < 2000) ? 70 : 30;
        av = ($urandom_range(0, 99) < 70);
        if ($urandom_range(0, 15) == 0) f = 4'($urandom);
        else if ($urandom_range(0, 7) == 0) f = 4'd4;
        else f = 4'($urandom_range(0, 3));
        cv = ($urandom_range(0, 99) < cdb_pct);
        if (q.size() > 0 && $urandom_range(0, 3) != 0)
          ci = 3'(q[$urandom_range(0, q.size() - 1)].idx);
        else
          ci = 3'($urandom);
        drive(1'b0, av, f, 4'($urandom), cv, ci, 16'($urandom));
      end
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
